// File: rtl/edf_ic_pkg.sv
// Shared types for the EDF interrupt controller: time/deadline width and
// the stamper handshake FSM states.
package edf_ic_pkg;

  localparam int DefTimeWidth = 16;

  typedef logic [DefTimeWidth-1:0] dl_t;

  typedef enum logic {
    IDLE,
    PRESENT
  } stamp_state_e;

endpackage

// File: rtl/edf_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping past NrIrqs-1 back to 0.
module edf_rr_arbiter #(
  parameter int NrIrqs  = 2,
  parameter int IdWidth = (NrIrqs > 1) ? $clog2(NrIrqs) : 1
) (
  input  logic [NrIrqs-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic [IdWidth-1:0] gnt_id,
  output logic               any
);

  assign any = |req;

  always_comb begin
    int   idx;
    logic found;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NrIrqs; off++) begin
      idx = (int'(ptr) + off) % NrIrqs;
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = IdWidth'(idx);
      end
    end
  end

endmodule

// File: rtl/edf_irq_stamper.sv
// Edge-detects interrupt lines, stamps each edge with time + rel_dl and
// serialises (id, deadline) into the priority-queue insert port.
// Optional sticky drop reporting on drop_o when EDF_STAMP_DROP_EN is defined.
module edf_irq_stamper
  import edf_ic_pkg::*;
#(
  parameter int NrIrqs       = 2,
  parameter int TimeWidth    = DefTimeWidth,
  parameter int DefaultRelDl = 64,
  localparam int IdWidth     = (NrIrqs > 1) ? $clog2(NrIrqs) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NrIrqs-1:0]    irq_i,
  input  logic                 cfg_we_i,
  input  logic [IdWidth-1:0]   cfg_id_i,
  input  logic [TimeWidth-1:0] cfg_dl_i,
  output logic [TimeWidth-1:0] time_o,
  output logic                 push_valid_o,
  input  logic                 push_ready_i,
  output logic [IdWidth-1:0]   push_id_o,
  output logic [TimeWidth-1:0] push_dl_o
`ifdef EDF_STAMP_DROP_EN
  ,
  output logic [NrIrqs-1:0]    drop_o
`endif
);

  logic [TimeWidth-1:0]             time_q;
  logic [NrIrqs-1:0]                irq_q, pend_q, edge_det, clr, set_ok;
  logic [NrIrqs-1:0][TimeWidth-1:0] rel_dl, abs_dl;
  logic [IdWidth-1:0]               rr_ptr, sel_id, push_id_q;
  logic [TimeWidth-1:0]             push_dl_q;
  logic                             any_pend, load, hs;
  stamp_state_e                     state_q, state_d;

  assign time_o       = time_q;
  assign push_valid_o = (state_q == PRESENT);
  assign push_id_o    = push_id_q;
  assign push_dl_o    = push_dl_q;

  assign edge_det = irq_i & ~irq_q;
  assign clr      = hs ? (NrIrqs'(1) << push_id_q) : '0;
  // The handshake clear frees the slot, so an edge in that same cycle re-arms it.
  assign set_ok   = edge_det & (~pend_q | clr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q <= '0;
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      time_q <= time_q + 1'b1;
      irq_q  <= irq_i;
      pend_q <= (pend_q & ~clr) | set_ok;
    end
  end

  for (genvar i = 0; i < NrIrqs; i++) begin : g_src
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rel_dl[i] <= TimeWidth'(DefaultRelDl);
        abs_dl[i] <= '0;
      end else begin
        if (cfg_we_i && 32'(cfg_id_i) == i) rel_dl[i] <= cfg_dl_i;
        if (set_ok[i])                      abs_dl[i] <= time_q + rel_dl[i];
      end
    end
  end

`ifdef EDF_STAMP_DROP_EN
  logic [NrIrqs-1:0] drop_q, drop_ev, drop_clr;

  assign drop_ev = edge_det & pend_q & ~clr;
  assign drop_o  = drop_q;

  always_comb begin
    drop_clr = '0;
    if (cfg_we_i && 32'(cfg_id_i) < NrIrqs) drop_clr = NrIrqs'(1) << cfg_id_i;
  end

  // A drop in the same cycle as the clearing write still gets reported.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_q <= '0;
    else         drop_q <= (drop_q & ~drop_clr) | drop_ev;
  end
`endif

  edf_rr_arbiter #(
    .NrIrqs  (NrIrqs),
    .IdWidth (IdWidth)
  ) u_arb (
    .req    (pend_q),
    .ptr    (rr_ptr),
    .gnt_id (sel_id),
    .any    (any_pend)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hs      = 1'b0;
    case (state_q)
      IDLE: if (any_pend) begin
        load    = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: if (push_ready_i) begin
        hs      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      push_id_q <= '0;
      push_dl_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        push_id_q <= sel_id;
        push_dl_q <= abs_dl[sel_id];
      end
      if (hs) rr_ptr <= (32'(push_id_q) == NrIrqs - 1) ? '0 : push_id_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_edf_irq_stamper.sv
// Directed bench for edf_irq_stamper (NrIrqs=4, TimeWidth=8, DefaultRelDl=16).
module tb_edf_irq_stamper;

  logic       clk_i, rst_ni;
  logic [3:0] irq_i;
  logic       cfg_we_i;
  logic [1:0] cfg_id_i;
  logic [7:0] cfg_dl_i;
  logic [7:0] time_o;
  logic       push_valid_o, push_ready_i;
  logic [1:0] push_id_o;
  logic [7:0] push_dl_o;
`ifdef EDF_STAMP_DROP_EN
  logic [3:0] drop_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  edf_irq_stamper #(
    .NrIrqs       (4),
    .TimeWidth    (8),
    .DefaultRelDl (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_i        (irq_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_id_i     (cfg_id_i),
    .cfg_dl_i     (cfg_dl_i),
    .time_o       (time_o),
    .push_valid_o (push_valid_o),
    .push_ready_i (push_ready_i),
    .push_id_o    (push_id_o),
    .push_dl_o    (push_dl_o)
`ifdef EDF_STAMP_DROP_EN
    ,
    .drop_o       (drop_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_time(input logic [7:0] t);
    int n = 0;
    while (time_o != t && n < 300) begin
      tick();
      n++;
    end
    chk("wait_time", 32'(time_o), 32'(t));
  endtask

  // After tick(): valid/id/dl of the entry being presented.
  task automatic chk_push(input string tag, input logic [1:0] id, input logic [7:0] dl);
    chk({tag, "_vld"}, 32'(push_valid_o), 32'd1);
    chk({tag, "_id"},  32'(push_id_o),    32'(id));
    chk({tag, "_dl"},  32'(push_dl_o),    32'(dl));
  endtask

  initial begin
    logic [7:0] exp_dl;
    rst_ni = 1'b0; irq_i = '0; cfg_we_i = 1'b0; cfg_id_i = '0; cfg_dl_i = '0;
    push_ready_i = 1'b1;
    #22;
    chk("rst_vld",  32'(push_valid_o), 32'd0);
    chk("rst_id",   32'(push_id_o),    32'd0);
    chk("rst_dl",   32'(push_dl_o),    32'd0);
    chk("rst_time", 32'(time_o),       32'd0);
`ifdef EDF_STAMP_DROP_EN
    chk("rst_drop", 32'(drop_o),       32'd0);
`endif
    rst_ni = 1'b1;
    tick();

    // Round-robin from rr_ptr=0: 0,1,3 two cycles apart
    irq_i  = 4'b1011;
    exp_dl = time_o + 8'd16;
    tick();
    chk("rr_idle", 32'(push_valid_o), 32'd0);
    tick(); chk_push("rr_a0", 2'd0, exp_dl);
    tick(); chk("rr_gap0", 32'(push_valid_o), 32'd0);
    tick(); chk_push("rr_a1", 2'd1, exp_dl);
    tick(); chk("rr_gap1", 32'(push_valid_o), 32'd0);
    tick(); chk_push("rr_a3", 2'd3, exp_dl);
    tick(); chk("rr_end", 32'(push_valid_o), 32'd0);
    irq_i = '0;
    tick();
    irq_i  = 4'b1001;
    exp_dl = time_o + 8'd16;
    tick();
    tick(); chk_push("rr_b0", 2'd0, exp_dl);
    tick();
    tick(); chk_push("rr_b3", 2'd3, exp_dl);
    tick(); chk("rr_b_end", 32'(push_valid_o), 32'd0);
    irq_i = '0;

    // Single source sampled at time 5 -> dl 21; held level gives nothing more
    wait_time(8'd5);
    irq_i = 4'b0100;
    tick(); chk("s_idle", 32'(push_valid_o), 32'd0);
    tick(); chk_push("s_push", 2'd2, 8'd21);
    tick(); chk("s_done", 32'(push_valid_o), 32'd0);
    tick(); chk("s_level", 32'(push_valid_o), 32'd0);
    tick(); chk("s_level2", 32'(push_valid_o), 32'd0);
    irq_i = '0;

    // Backpressure: id/dl stable while ready is low
    push_ready_i = 1'b0;
    irq_i  = 4'b0010;
    exp_dl = time_o + 8'd16;
    tick();
    tick(); chk_push("bp_first", 2'd1, exp_dl);
    for (int k = 0; k < 10; k++) begin
      tick(); chk_push("bp_hold", 2'd1, exp_dl);
    end
    push_ready_i = 1'b1;
    tick(); chk("bp_acc", 32'(push_valid_o), 32'd0);
    irq_i = '0;
    tick(); chk("bp_none", 32'(push_valid_o), 32'd0);

    // Wrap-around: 100 + 200 mod 256 = 44
    cfg_we_i = 1'b1; cfg_id_i = 2'd1; cfg_dl_i = 8'd200;
    tick();
    cfg_we_i = 1'b0;
    wait_time(8'd100);
    irq_i = 4'b0010;
    tick();
    tick(); chk_push("wrap", 2'd1, 8'd44);
    tick(); chk("wrap_done", 32'(push_valid_o), 32'd0);
    irq_i = '0;

    // Drop: second edge while pending keeps the original deadline
    push_ready_i = 1'b0;
    wait_time(8'd14);
    irq_i = 4'b0001;
    tick();
    irq_i = '0;
    tick(); chk_push("drop_first", 2'd0, 8'd30);
    irq_i = 4'b0001;
    tick();
    irq_i = '0;
    tick(); chk_push("drop_keep", 2'd0, 8'd30);
`ifdef EDF_STAMP_DROP_EN
    chk("drop_flag", 32'(drop_o), 32'd1);
`endif
    push_ready_i = 1'b1;
    tick(); chk("drop_acc", 32'(push_valid_o), 32'd0);
    tick(); chk("drop_single", 32'(push_valid_o), 32'd0);
    tick(); chk("drop_single2", 32'(push_valid_o), 32'd0);
`ifdef EDF_STAMP_DROP_EN
    chk("drop_sticky", 32'(drop_o), 32'd1);
    cfg_we_i = 1'b1; cfg_id_i = 2'd0; cfg_dl_i = 8'd16;
    tick();
    cfg_we_i = 1'b0;
    chk("drop_clr", 32'(drop_o), 32'd0);
`endif

    // Reset while presenting: valid drops asynchronously
    push_ready_i = 1'b0;
    irq_i = 4'b1000;
    tick();
    tick(); chk("rstm_vld", 32'(push_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstm_vld0", 32'(push_valid_o), 32'd0);
    chk("rstm_time", 32'(time_o),       32'd0);
    irq_i = '0;
    push_ready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); chk("rstm_quiet", 32'(push_valid_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
